// File: rtl/scoreboard_frame_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : scoreboard_frame_rx_if
//  Brief    : Byte stream in / committed frame out bundle for the scoreboard
//             frame receiver. The master drives the UART byte stream and
//             observes the frame; the slave is the frame receiver.
//  Revision : 1.0 - initial release
// ============================================================================
interface scoreboard_frame_rx_if #(
    parameter int NUM_BYTES = 20
);
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic [7:0] data [NUM_BYTES-1:0];
    logic       frame_strobe;
    logic       frame_err;
    logic       stale;

    modport master (
        output rx_data, rx_valid, rx_error,
        input  data, frame_strobe, frame_err, stale
    );

    modport slave (
        input  rx_data, rx_valid, rx_error,
        output data, frame_strobe, frame_err, stale
    );
endinterface
`default_nettype wire

// File: rtl/scoreboard_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : scoreboard_frame_rx
//  Brief    : Assembles UART bytes into a NUM_BYTES frame in a shadow buffer
//             and publishes only complete, error-free frames in one edge.
//             Inter-byte gaps and line errors drop the partial frame; loss of
//             stream for STALE_CYCLES blanks the published frame to zero.
//             Optional macro FRAME_CHECKSUM_EN appends a trailing XOR check
//             byte that must match before a frame is committed.
//  Revision : 1.0 - initial release
// ============================================================================
module scoreboard_frame_rx #(
    parameter int NUM_BYTES    = 20,
    parameter int GAP_CYCLES   = 1000,
    parameter int STALE_CYCLES = 50000000
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    scoreboard_frame_rx_if.slave bus
);

    localparam int c_IDX_W   = $clog2(NUM_BYTES + 1);
    localparam int c_GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int c_STALE_W = $clog2(STALE_CYCLES + 1);

`ifdef FRAME_CHECKSUM_EN
    // The check byte sits one position past the payload.
    localparam logic [c_IDX_W-1:0] c_FINAL_IDX = c_IDX_W'(NUM_BYTES);
`else
    localparam logic [c_IDX_W-1:0] c_FINAL_IDX = c_IDX_W'(NUM_BYTES - 1);
`endif

    localparam logic [c_GAP_W-1:0]   c_GAP_LAST   = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [c_STALE_W-1:0] c_STALE_LAST = c_STALE_W'(STALE_CYCLES - 1);
    localparam logic [c_STALE_W-1:0] c_STALE_MAX  = c_STALE_W'(STALE_CYCLES);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_DISCARD = 2'd2;

    logic [1:0]           r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_GAP_W-1:0]   r_gap;
    logic [c_STALE_W-1:0] r_stale_cnt;
    logic [7:0]           r_shadow [NUM_BYTES-1:0];
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]           r_xor;
`endif

    logic [1:0]           w_next_state;
    logic [c_IDX_W-1:0]   w_idx_next;
    logic [c_GAP_W-1:0]   w_gap_next;
    logic                 w_store;
    logic                 w_commit;
    logic                 w_drop;
    logic [7:0]           w_frame [NUM_BYTES-1:0];

    // Next-state, byte indexing and gap timing; commit and drop are exclusive.
    always_comb begin
        w_next_state = r_state;
        w_idx_next   = r_idx;
        w_gap_next   = r_gap;
        w_store      = 1'b0;
        w_commit     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            c_IDLE, c_COLLECT: begin
                if (bus.rx_error) begin
                    // Error wins over a simultaneous byte.
                    w_drop       = 1'b1;
                    w_next_state = c_DISCARD;
                    w_idx_next   = '0;
                    w_gap_next   = '0;
                end else if (bus.rx_valid) begin
                    w_gap_next = '0;
                    if (r_idx == c_FINAL_IDX) begin
                        w_idx_next   = '0;
                        w_next_state = c_IDLE;
`ifdef FRAME_CHECKSUM_EN
                        if (bus.rx_data == r_xor) begin
                            w_commit = 1'b1;
                        end else begin
                            w_drop = 1'b1;
                        end
`else
                        w_commit = 1'b1;
`endif
                    end else begin
                        w_store      = 1'b1;
                        w_idx_next   = r_idx + c_IDX_W'(1);
                        w_next_state = c_COLLECT;
                    end
                end else if (r_state == c_COLLECT) begin
                    if (r_gap == c_GAP_LAST) begin
                        w_drop       = 1'b1;
                        w_next_state = c_IDLE;
                        w_idx_next   = '0;
                        w_gap_next   = '0;
                    end else begin
                        w_gap_next = r_gap + c_GAP_W'(1);
                    end
                end
            end
            c_DISCARD: begin
                // Wait for a silent line before trusting the next byte as a frame start.
                if (bus.rx_valid || bus.rx_error) begin
                    w_gap_next = '0;
                end else if (r_gap == c_GAP_LAST) begin
                    w_next_state = c_IDLE;
                    w_gap_next   = '0;
                end else begin
                    w_gap_next = r_gap + c_GAP_W'(1);
                end
            end
            default: begin
                w_next_state = c_IDLE;
                w_idx_next   = '0;
                w_gap_next   = '0;
            end
        endcase
    end

    // Frame to publish: shadow contents, plus the live final byte when there is no check byte.
    always_comb begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            w_frame[i] = r_shadow[i];
        end
`ifndef FRAME_CHECKSUM_EN
        w_frame[NUM_BYTES-1] = bus.rx_data;
`endif
    end

    // State register with byte index and gap counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_idx_next;
            r_gap   <= w_gap_next;
        end
    end

    // Shadow buffer (and running XOR); contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_shadow[r_idx] <= bus.rx_data;
`ifdef FRAME_CHECKSUM_EN
            r_xor <= (r_idx == '0) ? bus.rx_data : (r_xor ^ bus.rx_data);
`endif
        end
    end

    // Published frame, pulses and stale tracking; a commit beats stale blanking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                bus.data[i] <= 8'h00;
            end
            bus.frame_strobe <= 1'b0;
            bus.frame_err    <= 1'b0;
            bus.stale        <= 1'b1;
            r_stale_cnt      <= '0;
        end else begin
            bus.frame_strobe <= w_commit;
            bus.frame_err    <= w_drop;
            if (w_commit) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    bus.data[i] <= w_frame[i];
                end
                bus.stale   <= 1'b0;
                r_stale_cnt <= '0;
            end else if (r_stale_cnt == c_STALE_LAST) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    bus.data[i] <= 8'h00;
                end
                bus.stale   <= 1'b1;
                r_stale_cnt <= c_STALE_MAX;
            end else if (r_stale_cnt != c_STALE_MAX) begin
                r_stale_cnt <= r_stale_cnt + c_STALE_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scoreboard_frame_rx
//  Brief    : Self-checking bench for scoreboard_frame_rx. Expected commit /
//             drop events are queued as stimulus is driven and retired by a
//             monitor as frame_strobe / frame_err pulses appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scoreboard_frame_rx;

    localparam int NB    = 20;
    localparam int GAP   = 16;
    localparam int STALE = 1000;
`ifdef FRAME_CHECKSUM_EN
    localparam int NBT = NB + 1;
`else
    localparam int NBT = NB;
`endif

    typedef logic [NB-1:0][7:0] frame_t;
    typedef struct {
        bit     good;
        frame_t frame;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scoreboard_frame_rx_if #(.NUM_BYTES(NB)) bus ();

    scoreboard_frame_rx #(
        .NUM_BYTES    (NB),
        .GAP_CYCLES   (GAP),
        .STALE_CYCLES (STALE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb_q[$];
    int unsigned cyc      = 0;
    bit          mon_en   = 1'b0;
    frame_t      prev_data;
    logic        prev_stale;
    frame_t      mon_d;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic frame_t cur_data();
        frame_t f;
        for (int i = 0; i < NB; i++) f[i] = bus.data[i];
        return f;
    endfunction

    function automatic frame_t fill(input logic [7:0] v);
        frame_t f;
        for (int i = 0; i < NB; i++) f[i] = v;
        return f;
    endfunction

    function automatic frame_t ramp();
        frame_t f;
        for (int i = 0; i < NB; i++) f[i] = 8'(i + 1);
        return f;
    endfunction

    task automatic check(input string tag, input logic [NB*8-1:0] got, input logic [NB*8-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic byte_in(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic err_in(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        bus.rx_error = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
    endtask

    // Sends a full frame; returns at the first sample after the final byte.
    task automatic send_frame(input frame_t f, input int spacing, input bit corrupt);
        exp_t       e;
        logic [7:0] x;
        e.good  = !corrupt;
        e.frame = f;
        sb_q.push_back(e);
        x = 8'h00;
        for (int i = 0; i < NB; i++) begin
            byte_in(f[i]);
            x = x ^ f[i];
            if (i < NBT - 1) idle(spacing);
        end
`ifdef FRAME_CHECKSUM_EN
        byte_in(corrupt ? (x ^ 8'h01) : x);
`endif
        check("final_strobe", bus.frame_strobe, !corrupt);
        check("final_err", bus.frame_err, corrupt);
    endtask

    // Monitor: retire queued events on pulses and catch any unexplained data change.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mon_d = cur_data();
                check("data_hold",
                      (mon_d != prev_data) && !bus.frame_strobe && !(bus.stale && !prev_stale), 0);
                if (bus.frame_strobe || bus.frame_err) begin
                    check("pulse_excl", bus.frame_strobe && bus.frame_err, 0);
                    check("sb_pending", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        mon_e = sb_q.pop_front();
                        check("pulse_kind", bus.frame_strobe, mon_e.good);
                        if (mon_e.good && bus.frame_strobe) check("frame_data", mon_d, mon_e.frame);
                    end
                end
                prev_data  = mon_d;
                prev_stale = bus.stale;
            end
        end
    end

    initial begin
        exp_t        e;
        int unsigned t1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        rst_n        = 1'b0;
        idle(3);
        check("rst_data", cur_data(), '0);
        check("rst_strobe", bus.frame_strobe, 0);
        check("rst_err", bus.frame_err, 0);
        check("rst_stale", bus.stale, 1);
        rst_n      = 1'b1;
        prev_data  = cur_data();
        prev_stale = bus.stale;
        mon_en     = 1'b1;
        idle(1);

        // Ramp frame: first commit clears stale.
        check("pre_stale", bus.stale, 1);
        send_frame(ramp(), 3, 1'b0);
        check("ramp_data", cur_data(), ramp());
        check("ramp_stale", bus.stale, 0);
        idle(3);

        // Partial frame timed out by the gap counter, then a good 0xA5 frame.
        for (int i = 0; i < 12; i++) begin
            byte_in(8'h5A);
            idle(3);
        end
        e.good  = 1'b0;
        e.frame = '0;
        sb_q.push_back(e);
        idle(12);
        check("gap_err_early", bus.frame_err, 0);
        idle(1);
        check("gap_err", bus.frame_err, 1);
        check("gap_data_kept", cur_data(), ramp());
        send_frame(fill(8'hA5), 3, 1'b0);
        idle(3);

        // Line error on byte 7, more bytes while discarding, silence, then 0x3C.
        for (int i = 0; i < 6; i++) begin
            byte_in(8'h77);
            idle(3);
        end
        sb_q.push_back(e);
        err_in(8'h77);
        check("line_err", bus.frame_err, 1);
        idle(3);
        for (int i = 0; i < 5; i++) begin
            byte_in(8'h99);
            idle(3);
        end
        idle(GAP - 3);
        check("discard_data_kept", cur_data(), fill(8'hA5));
        send_frame(fill(8'h3C), 3, 1'b0);

        // Stale blanking exactly STALE cycles after the commit.
        idle(STALE - 1);
        check("stale_early", bus.stale, 0);
        idle(1);
        check("stale_set", bus.stale, 1);
        check("stale_blank", cur_data(), '0);

        // Commit landing on the stale threshold cycle wins.
        send_frame(fill(8'h55), 3, 1'b0);
        idle(STALE - 1 - (NBT - 1) * 4);
        send_frame(fill(8'h66), 3, 1'b0);
        check("thresh_stale", bus.stale, 0);
        check("thresh_data", cur_data(), fill(8'h66));
        idle(2);
        check("thresh_stale_hold", bus.stale, 0);

        // Back-to-back frames with no gap at all.
        send_frame(fill(8'h11), 0, 1'b0);
        t1 = cyc;
        send_frame(fill(8'h22), 0, 1'b0);
        check("b2b_period", cyc - t1, NBT);
        idle(3);

`ifdef FRAME_CHECKSUM_EN
        // Wrong check byte drops the frame; the right one commits it.
        send_frame(fill(8'hA5), 3, 1'b0);
        idle(3);
        send_frame(ramp(), 3, 1'b1);
        check("csum_bad_data", cur_data(), fill(8'hA5));
        idle(3);
        send_frame(ramp(), 3, 1'b0);
        check("csum_good_data", cur_data(), ramp());
        idle(3);
`endif

        idle(4);
        check("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scoreboard_frame_rx.md
Name: scoreboard_frame_rx

Overview:
- Receives the scoreboard update stream as bytes from the UART receiver and assembles them into the NUM_BYTES-byte frame array consumed by the segment decoder.
- Publishes only complete, error-free frames, atomically, through a shadow buffer.
- Detects inter-byte gaps, line errors and loss of stream.
- On stream loss, clears the frame to all-zero, which the decoder displays as blank.

Parameters:
- NUM_BYTES, 20, frame payload length in bytes; must match the decoder's data array depth.
- GAP_CYCLES, 1000, idle cycles after the last byte that terminate or resynchronise a frame; ≥2.
- STALE_CYCLES, 50000000, cycles without a committed frame before output is blanked; ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- rx_data  in  8  received byte, valid when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- rx_error  in  1  one-cycle strobe: UART framing/parity error on the current byte
- data  out  8 x NUM_BYTES  committed frame, unpacked array [NUM_BYTES-1:0] of [7:0], registered
- frame_strobe  out  1  one-cycle pulse when data is updated by a good frame
- frame_err  out  1  one-cycle pulse when a frame is dropped
- stale  out  1  level: no good frame within STALE_CYCLES

Behaviour:
- Reset (rst_n=0 at an edge):
  - all data bytes=0; frame_strobe=0; frame_err=0; stale=1.
  - State=IDLE, byte index=0, gap and stale counters=0, shadow buffer contents don't-care.
- States: IDLE, COLLECT, DISCARD.
- IDLE:
  - rx_valid (without rx_error) → shadow[0]=rx_data, index=1, gap counter=0, go COLLECT.
  - rx_error → frame_err pulse, go DISCARD.
- COLLECT:
  - rx_valid → shadow[index]=rx_data, index+1, gap counter cleared.
  - On the final byte (index=NUM_BYTES-1), data takes the shadow contents plus the final byte at the same edge, so the new frame is visible the cycle after the final rx_valid.
  - frame_strobe pulses in that same following cycle; state returns to IDLE.
  - With no rx_valid, gap counter increments. At GAP_CYCLES: frame_err pulse, data unchanged, go IDLE.
- DISCARD:
  - Any rx_valid or rx_error clears the gap counter.
  - GAP_CYCLES of silence → IDLE with no pulse. This resynchronises to the next frame start.
- rx_error in COLLECT → frame_err pulse, partial frame dropped, go DISCARD.
- rx_error and rx_valid in the same cycle: the error wins and the byte is ignored.
- Back-to-back frames need no gap: a byte in the cycle after a commit starts the next frame.
- data changes only on a commit or on stale blanking; never partially.
- Stale counter:
  - Increments every cycle and saturates at STALE_CYCLES.
  - Cleared at the commit edge, which also drives stale=0 from the next cycle.
  - On reaching STALE_CYCLES: stale=1 and all data bytes=0 in the same cycle.
  - A commit on the threshold cycle wins: data is the new frame, stale=0.
- frame_strobe and frame_err are never both high in one cycle.
- Counter widths use $clog2(parameter+1); there is no wrap.

Optional Feature:
- Macro FRAME_CHECKSUM_EN.
- Defined:
  - The frame is NUM_BYTES payload bytes plus one trailing check byte, equal to the XOR of all payload bytes.
  - After the check byte, commit only on a match. On a mismatch: frame_err pulse, data unchanged, stale counter not cleared, go IDLE.
  - Gap and error rules also apply while waiting for the check byte.
- Undefined:
  - The frame is exactly NUM_BYTES bytes with no integrity check.
  - No XOR logic is synthesised.

Test Plan (NUM_BYTES=20, GAP_CYCLES=16, STALE_CYCLES=1000):
- Reset, then 20 bytes 0x01..0x14, one every 4 cycles → data[i]=i+1 in the cycle after the 20th rx_valid, one frame_strobe, stale 1→0.
- 12 bytes, then 16 idle cycles, then a full frame of 0xA5 → one frame_err at gap expiry, data still previous, then data all 0xA5 with frame_strobe.
- rx_error with byte 7; a further 5 bytes spaced under 16 cycles; 16 idle cycles; a full frame of 0x3C → a single frame_err, no commit until the 0x3C frame, which commits.
- After a good frame, no input for 1000 cycles → stale=1 and data all zero exactly at the threshold. A frame completing on the threshold cycle → data is the new frame and stale stays 0.
- Two back-to-back frames (0x11s then 0x22s), no gap → two frame_strobes 20 byte-periods apart; data never mixes the two values.
- FRAME_CHECKSUM_EN with payload 0x01..0x14: check byte 0x14 commits; check byte 0x15 gives frame_err and data unchanged.
